// File: rtl/hidden_stream_sequencer.sv
// hidden_stream_sequencer: feeds one inference's hidden-layer activations into the
// hidden-to-output accumulator. Each accepted value is presented with its 1-based node
// index while mult_en is pulsed for MULT_HOLD cycles, then held low for MULT_GAP cycles.
// After the last node the sequencer waits for the accumulator's final_flag, with a
// timeout that completes with a sticky error.
module hidden_stream_sequencer #(
    parameter int unsigned HIDDEN_NODES  = 3000,
    parameter int unsigned MULT_HOLD     = 6,
    parameter int unsigned MULT_GAP      = 2,
    parameter int unsigned FINAL_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               h_valid,
    input  logic signed [31:0] h_data,
    output logic               h_ready,
    input  logic               final_flag,
    output logic [12:0]        node_index,
    output logic signed [31:0] hidden_node,
    output logic               mult_en,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // One shared cycle counter times HOLD, GAP and the WAIT_FINAL timeout.
    localparam int unsigned HoldGapMax = (MULT_HOLD > MULT_GAP) ? MULT_HOLD : MULT_GAP;
    localparam int unsigned CntMax     = (HoldGapMax > FINAL_TIMEOUT) ? HoldGapMax
                                                                      : FINAL_TIMEOUT;
    localparam int unsigned CntW       = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] HoldLast    = CntW'(MULT_HOLD - 1);
    localparam logic [CntW-1:0] GapLast     = CntW'(MULT_GAP - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(FINAL_TIMEOUT - 1);
    localparam logic [12:0]     LastNode    = 13'(HIDDEN_NODES);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StHold,
        StGap,
        StWaitFinal,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [12:0]        node_q, node_d;
    logic signed [31:0] hid_q, hid_d;
    logic               seen_q, seen_d;
    logic               err_q, err_d;
    logic               mult_en_q, mult_en_d;
    logic               h_ready_q, h_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic handshake;
    logic at_last;

    assign handshake = h_valid & h_ready_q;
    assign at_last   = (node_q == LastNode);

    // Next-state, datapath updates and registered-output precomputation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        node_d  = node_q;
        hid_d   = hid_q;
        seen_d  = seen_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                // node_index keeps its last value here so finished results survive.
                if (start) begin
                    state_d = StClear;
                    err_d   = 1'b0;
                    node_d  = '0;
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                end
            end

            StClear: begin
                state_d = StFetch;
                cnt_d   = '0;
            end

            StFetch: begin
                if (handshake) begin
                    hid_d   = h_data;
                    // Saturate rather than wrap; GAP routes to WAIT_FINAL at the last node.
                    if (!at_last) begin
                        node_d = node_q + 13'd1;
                    end
                    cnt_d   = '0;
                    state_d = StHold;
                end
            end

            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = at_last ? StWaitFinal : StFetch;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StWaitFinal: begin
                if (seen_q) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Remember the accumulator's last-node indication until WAIT_FINAL consumes it.
        if (final_flag && at_last &&
            (state_q == StHold || state_q == StGap || state_q == StWaitFinal)) begin
            seen_d = 1'b1;
        end

        // Outputs are registered copies of what the next state implies.
        mult_en_d = (state_d == StHold);
        h_ready_d = (state_d == StFetch);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            node_q    <= '0;
            hid_q     <= '0;
            seen_q    <= 1'b0;
            err_q     <= 1'b0;
            mult_en_q <= 1'b0;
            h_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            node_q    <= node_d;
            hid_q     <= hid_d;
            seen_q    <= seen_d;
            err_q     <= err_d;
            mult_en_q <= mult_en_d;
            h_ready_q <= h_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign node_index  = node_q;
    assign hidden_node = hid_q;
    assign mult_en     = mult_en_q;
    assign h_ready     = h_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_hidden_stream_sequencer.sv
// Scoreboard bench for hidden_stream_sequencer with 4 hidden nodes.
// Stimulus pushes expected node/done events; a negedge monitor pops and compares them.
module tb_hidden_stream_sequencer;

    localparam int N      = 4;
    localparam int LAT    = 2 + N * 9;          // done edge offset from the start edge
    localparam int TO_LAT = 2 + N * 9 - 1 + 16; // done edge offset on timeout

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               h_valid = 1'b0;
    logic signed [31:0] h_data;
    logic               h_ready;
    logic               final_flag;
    logic [12:0]        node_index;
    logic signed [31:0] hidden_node;
    logic               mult_en;
    logic               busy;
    logic               done;
    logic               err;

    logic signed [31:0] feed_tab [4];
    logic               final_en = 1'b1;
    longint             cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit     is_done;
        int     idx;
        int     data;
        longint edge_no;
        bit     err;
    } exp_t;
    exp_t exp_q[$];

    hidden_stream_sequencer #(
        .HIDDEN_NODES (N),
        .MULT_HOLD    (6),
        .MULT_GAP     (2),
        .FINAL_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .h_valid    (h_valid),
        .h_data     (h_data),
        .h_ready    (h_ready),
        .final_flag (final_flag),
        .node_index (node_index),
        .hidden_node(hidden_node),
        .mult_en    (mult_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source offers the next table entry while ready, junk otherwise.
    always_comb begin
        if (h_ready) h_data = feed_tab[node_index[1:0]];
        else         h_data = 32'h5A5A_0000 | 32'(cyc[15:0]);
    end

    // Accumulator model: flags the last node while it is being multiplied.
    assign final_flag = final_en && mult_en && (node_index == 13'(N));

    task automatic check(input string name, input longint act, input longint exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic push_nodes(input int d0, input int d1, input int d2, input int d3);
        int d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int k = 0; k < N; k++) begin
            exp_q.push_back('{is_done: 1'b0, idx: k + 1, data: d[k], edge_no: 0, err: 1'b0});
        end
    endtask

    task automatic push_done(input longint e, input bit er);
        exp_q.push_back('{is_done: 1'b1, idx: 0, data: 0, edge_no: e, err: er});
    endtask

    task automatic set_tab(input int d0, input int d1, input int d2, input int d3);
        feed_tab[0] = d0; feed_tab[1] = d1; feed_tab[2] = d2; feed_tab[3] = d3;
    endtask

    // Called at a negedge; returns at the negedge after the edge that samples start.
    task automatic start_run(output longint s_edge);
        start  = 1'b1;
        s_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic wait_node_hold(input int idx, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (mult_en && node_index == 13'(idx)) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("hold_wait_timeout", 0, 1);
    endtask

    // Monitor: one node event per mult_en pulse, one done event per done pulse.
    int                 hold_cnt = 0;
    bit                 in_hold = 1'b0;
    bit                 stable = 1'b1;
    logic [12:0]        cap_idx;
    logic signed [31:0] cap_data;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_hold  = 1'b0;
            hold_cnt = 0;
        end else begin
            if (mult_en) begin
                if (!in_hold) begin
                    in_hold  = 1'b1;
                    hold_cnt = 1;
                    cap_idx  = node_index;
                    cap_data = hidden_node;
                    stable   = 1'b1;
                end else begin
                    hold_cnt++;
                    if (node_index != cap_idx || hidden_node != cap_data) stable = 1'b0;
                end
            end else if (in_hold) begin
                in_hold = 1'b0;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    check("unexpected_node_event", longint'(cap_idx), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("node_index", longint'(cap_idx), e.idx);
                    check("hidden_node", longint'(cap_data), e.data);
                    check("hold_cycles", hold_cnt, 6);
                    check("hold_stable", stable, 1);
                end
            end
            if (done) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    check("unexpected_done", cyc, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_edge", cyc, e.edge_no);
                    check("done_err", err, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint s, s2;
        bit     saw_gap_err;

        set_tab(10, 20, -30, 40);
        h_valid = 1'b1;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_node_index", node_index, 0);
        check("rst_hidden_node", hidden_node, 0);
        check("rst_mult_en", mult_en, 0);
        check("rst_h_ready", h_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic run.
        start_run(s);
        check("clear_node_index", node_index, 0);
        check("clear_busy", busy, 1);
        push_nodes(10, 20, -30, 40);
        push_done(s + LAT, 1'b0);
        wait_done(200);
        repeat (3) @(negedge clk);
        check("idle_node_index_hold", node_index, N);
        check("idle_busy", busy, 0);
        check("idle_err", err, 0);

        // Stall before node 3.
        start_run(s);
        push_nodes(10, 20, -30, 40);
        push_done(s + LAT + 5, 1'b0);
        saw_gap_err = 1'b0;
        for (int i = 0; i < 100 && !(h_ready && node_index == 13'd2); i++) @(negedge clk);
        check("stall_reached", h_ready && node_index == 13'd2, 1);
        h_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_h_ready", h_ready, 1);
            check("stall_node_index", node_index, 2);
            check("stall_mult_en", mult_en, 0);
            @(negedge clk);
        end
        h_valid = 1'b1;
        wait_done(200);
        @(negedge clk);

        // Timeout: accumulator never flags the last node.
        final_en = 1'b0;
        start_run(s);
        push_nodes(10, 20, -30, 40);
        push_done(s + TO_LAT, 1'b1);
        wait_done(200);
        @(negedge clk);
        check("timeout_err_sticky", err, 1);
        check("timeout_idle", busy, 0);
        final_en = 1'b1;
        @(negedge clk);

        // Next start clears err; a start pulse during node 2 HOLD is ignored.
        start_run(s);
        check("start_clears_err", err, 0);
        push_nodes(10, 20, -30, 40);
        push_done(s + LAT, 1'b0);
        wait_node_hold(2, 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);
        check("ignored_start_idle", busy, 0);

        // Reset during node 3 HOLD.
        start_run(s);
        push_nodes(10, 20, -30, 40);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        wait_node_hold(3, 100);
        #2 rst = 1'b1;
        #1;
        check("midrst_node_index", node_index, 0);
        check("midrst_hidden_node", hidden_node, 0);
        check("midrst_mult_en", mult_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_h_ready", h_ready, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        set_tab(5, -6, 7, -8);
        start_run(s);
        push_nodes(5, -6, 7, -8);
        push_done(s + LAT, 1'b0);
        wait_done(200);
        @(negedge clk);

        // start held through DONE: exactly one extra run from the IDLE cycle.
        set_tab(10, 20, -30, 40);
        start = 1'b1;
        s     = cyc + 1;
        s2    = s + LAT + 2;
        push_nodes(10, 20, -30, 40);
        push_done(s + LAT, 1'b0);
        push_nodes(10, 20, -30, 40);
        push_done(s2 + LAT, 1'b0);
        @(negedge clk);
        wait_done(200);
        @(negedge clk);
        check("held_idle_busy", busy, 0);
        @(negedge clk);
        check("held_clear_busy", busy, 1);
        check("held_clear_node_index", node_index, 0);
        start = 1'b0;
        wait_done(200);
        repeat (20) @(negedge clk);
        check("held_single_extra_run", busy, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
